// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup for fetch, trained by execute, invalidated by a per-entry sweep.
module branch_target_buffer #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            hit_o,
  output logic [XLEN-1:0] target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            flush_i,
  output logic            busy_o
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 1;
  localparam logic [IDX:0] CLR_LAST = (IDX+1)'(ENTRIES - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [IDX:0]    clr_idx_q, clr_idx_d;

  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX-1:0]  look_idx;
  logic [TAGW-1:0] look_tag;
  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic            upd_en;
  logic            upd_match;
  logic            unused_pc_lsb;

  // Bit 0 of a PC never selects anything: halfword-aligned instructions.
  assign unused_pc_lsb = ^{pc_i[0], upd_pc_i[0]};

  assign look_idx = pc_i[IDX:1];
  assign look_tag = pc_i[XLEN-1:IDX+1];
  assign upd_idx  = upd_pc_i[IDX:1];
  assign upd_tag  = upd_pc_i[XLEN-1:IDX+1];

  assign busy_o   = (state_q == CLEAR);
  assign hit_o    = (state_q == IDLE) && valid_q[look_idx] &&
                    (tag_q[look_idx] == look_tag) && ctr_q[look_idx][1];
  assign target_o = target_q[look_idx];

  // Flush wins over a same-cycle update; updates are ignored while sweeping.
  assign upd_en    = upd_valid_i && (state_q == IDLE) && !flush_i && !rst_i;
  assign upd_match = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        if (flush_i) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == CLR_LAST) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + (IDX+1)'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      if (state_q == CLEAR) begin
        valid_q[clr_idx_q[IDX-1:0]] <= 1'b0;
      end
      if (upd_en && !upd_match && upd_taken_i) begin
        valid_q[upd_idx] <= 1'b1;
      end
    end
  end

  // Payload arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (upd_en) begin
      if (upd_match) begin
        if (upd_taken_i) begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          target_q[upd_idx] <= upd_target_i;
        end else begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule
